// File: rtl/checker_arb_pkg.sv
// Shared types and constants for the cpu_checker arbiter: FSM states,
// record delimiter characters and checker format codes.
package checker_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [7:0] CH_START = 8'h5E;
    localparam logic [7:0] CH_END   = 8'h23;
    localparam logic [7:0] CH_NUL   = 8'h00;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after
// ptr_i wins. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = IW'((32'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cpu_checker_arbiter.sv
// Grants a single cpu_checker to one trace source per ^...# record, streams
// the record's characters into it and returns the latched verdict.
module cpu_checker_arbiter
    import checker_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_char,
    input  logic [16*N_REQ-1:0]        req_freq,
    output logic [N_REQ-1:0]           req_ready,
    output logic [7:0]                 chk_char,
    output logic [15:0]                chk_freq,
    input  logic [1:0]                 chk_format_type,
    input  logic [3:0]                 chk_error_code,
    output logic                       res_valid,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic [1:0]                 res_format,
    output logic [3:0]                 res_error,
    output logic                       res_abort
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] len_inc;
    logic [7:0]    chk_char_q, chk_char_d;
    logic [15:0]   chk_freq_q, chk_freq_d;
    logic          res_valid_q, res_valid_d;
    logic [IW-1:0] res_id_q, res_id_d;
    logic [1:0]    res_format_q, res_format_d;
    logic [3:0]    res_error_q, res_error_d;
    logic          res_abort_q, res_abort_d;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] own_onehot;
    logic [N_REQ-1:0] win_gnt;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic             own_valid;
    logic [7:0]       own_char;
    logic [15:0]      win_freq;

    // Per-requester decode: start candidates, owner's lane, winner's freq
    always_comb begin
        cand       = '0;
        own_onehot = '0;
        own_valid  = 1'b0;
        own_char   = CH_NUL;
        win_freq   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand[i] = req_valid[i] && (req_char[8*i +: 8] == CH_START);
            if (IW'(i) == owner_q) begin
                own_onehot[i] = 1'b1;
                own_valid     = req_valid[i];
                own_char      = req_char[8*i +: 8];
            end
            if (IW'(i) == win_idx) begin
                win_freq = req_freq[16*i +: 16];
            end
        end
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req_i (cand),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        len_inc      = len_q + LW'(1);
        chk_char_d   = CH_NUL;
        chk_freq_d   = chk_freq_q;
        res_valid_d  = 1'b0;
        res_id_d     = res_id_q;
        res_format_d = res_format_q;
        res_error_d  = res_error_q;
        res_abort_d  = res_abort_q;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    req_ready  = win_gnt;
                    owner_d    = win_idx;
                    chk_freq_d = win_freq;
                    len_d      = LW'(1);
                    chk_char_d = CH_START;
                    state_d    = STREAM;
                end else begin
                    // No record start pending: swallow inter-record garbage
                    req_ready = req_valid;
                end
            end
            STREAM: begin
                req_ready = own_onehot;
                if (!own_valid || (own_char != CH_END && len_inc == LW'(MAX_LEN))) begin
                    res_abort_d  = 1'b1;
                    res_format_d = FMT_NONE;
                    res_error_d  = '0;
                    state_d      = RESP;
                end else if (own_char == CH_END) begin
                    chk_char_d  = CH_END;
                    len_d       = len_inc;
                    res_abort_d = 1'b0;
                    state_d     = WAIT;
                end else begin
                    chk_char_d = own_char;
                    len_d      = len_inc;
                end
            end
            WAIT: begin
                state_d = RESP;
            end
            RESP: begin
                res_valid_d = 1'b1;
                res_id_d    = owner_q;
                if (!res_abort_q) begin
                    res_format_d = chk_format_type;
                    res_error_d  = chk_error_code;
                end
                ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!reset) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            ptr_q        <= '0;
            len_q        <= '0;
            chk_char_q   <= CH_NUL;
            chk_freq_q   <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_format_q <= FMT_NONE;
            res_error_q  <= '0;
            res_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            chk_char_q   <= chk_char_d;
            chk_freq_q   <= chk_freq_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_format_q <= res_format_d;
            res_error_q  <= res_error_d;
            res_abort_q  <= res_abort_d;
        end
    end

    assign chk_char   = chk_char_q;
    assign chk_freq   = chk_freq_q;
    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_format = res_format_q;
    assign res_error  = res_error_q;
    assign res_abort  = res_abort_q;

endmodule

// File: tb/tb_cpu_checker_arbiter.sv
// Directed bench for cpu_checker_arbiter: a per-cycle vector table for two
// back-to-back records, plus sequences for abort, length limit and reset.
module tb_cpu_checker_arbiter;
    import checker_arb_pkg::*;

    localparam int unsigned N_REQ   = 2;
    localparam int unsigned MAX_LEN = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_char;
    logic [31:0] req_freq;
    logic [1:0]  req_ready;
    logic [7:0]  chk_char;
    logic [15:0] chk_freq;
    logic [1:0]  chk_format_type;
    logic [3:0]  chk_error_code;
    logic        res_valid;
    logic [0:0]  res_id;
    logic [1:0]  res_format;
    logic [3:0]  res_error;
    logic        res_abort;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    cpu_checker_arbiter #(
        .N_REQ   (N_REQ),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_char        (req_char),
        .req_freq        (req_freq),
        .req_ready       (req_ready),
        .chk_char        (chk_char),
        .chk_freq        (chk_freq),
        .chk_format_type (chk_format_type),
        .chk_error_code  (chk_error_code),
        .res_valid       (res_valid),
        .res_id          (res_id),
        .res_format      (res_format),
        .res_error       (res_error),
        .res_abort       (res_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  valid;
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic [1:0]  fmt_in;
        logic [3:0]  err_in;
        logic [1:0]  e_ready;
        logic [7:0]  e_chk;
        logic [15:0] e_freq;
        logic        e_rv;
        logic        e_rid;
        logic        e_abort;
        logic [1:0]  e_fmt;
        logic [3:0]  e_err;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i, input logic v, input logic [7:0] ch);
        if (i == 1'b0) begin
            req_valid[0]  = v;
            req_char[7:0] = ch;
        end else begin
            req_valid[1]   = v;
            req_char[15:8] = ch;
        end
    endtask

    initial begin
        logic [7:0] s3[4];
        s3 = '{8'h33, 8'h33, 8'h38, 8'h40};

        // Two records: garbage, simultaneous starts, then requester 1's turn
        tbl[0]  = '{2'b01, 8'h61,    8'h00,    2'd3,    4'hF, 2'b01, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0,    4'h0};
        tbl[1]  = '{2'b01, 8'h62,    8'h00,    2'd3,    4'hF, 2'b01, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0,    4'h0};
        tbl[2]  = '{2'b11, CH_START, CH_START, 2'd3,    4'hF, 2'b01, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0,    4'h0};
        tbl[3]  = '{2'b11, 8'h31,    CH_START, 2'd3,    4'hF, 2'b01, 8'h5E, 16'h0010, 1'b0, 1'b0, 1'b0, 2'd0,    4'h0};
        tbl[4]  = '{2'b11, CH_END,   CH_START, 2'd3,    4'hF, 2'b01, 8'h31, 16'h0010, 1'b0, 1'b0, 1'b0, 2'd0,    4'h0};
        tbl[5]  = '{2'b10, 8'h00,    CH_START, 2'd3,    4'hF, 2'b00, 8'h23, 16'h0010, 1'b0, 1'b0, 1'b0, 2'd0,    4'h0};
        tbl[6]  = '{2'b10, 8'h00,    CH_START, FMT_REG, 4'h5, 2'b00, 8'h00, 16'h0010, 1'b0, 1'b0, 1'b0, 2'd0,    4'h0};
        tbl[7]  = '{2'b10, 8'h00,    CH_START, 2'd3,    4'hF, 2'b10, 8'h00, 16'h0010, 1'b1, 1'b0, 1'b0, FMT_REG, 4'h5};
        tbl[8]  = '{2'b10, 8'h00,    8'h32,    2'd3,    4'hF, 2'b10, 8'h5E, 16'h1234, 1'b0, 1'b0, 1'b0, FMT_REG, 4'h5};
        tbl[9]  = '{2'b10, 8'h00,    CH_END,   2'd3,    4'hF, 2'b10, 8'h32, 16'h1234, 1'b0, 1'b0, 1'b0, FMT_REG, 4'h5};
        tbl[10] = '{2'b00, 8'h00,    8'h00,    2'd3,    4'hF, 2'b00, 8'h23, 16'h1234, 1'b0, 1'b0, 1'b0, FMT_REG, 4'h5};
        tbl[11] = '{2'b00, 8'h00,    8'h00,    FMT_MEM, 4'h3, 2'b00, 8'h00, 16'h1234, 1'b0, 1'b0, 1'b0, FMT_REG, 4'h5};
        tbl[12] = '{2'b00, 8'h00,    8'h00,    2'd3,    4'hF, 2'b00, 8'h00, 16'h1234, 1'b1, 1'b1, 1'b0, FMT_MEM, 4'h3};

        reset           = 1'b0;
        req_valid       = '0;
        req_char        = '0;
        req_freq        = {16'h1234, 16'h0010};
        chk_format_type = 2'd3;
        chk_error_code  = 4'hF;
        cyc();
        cyc();
        check("rst_chk_char",   32'(chk_char),   32'h0);
        check("rst_chk_freq",   32'(chk_freq),   32'h0);
        check("rst_req_ready",  32'(req_ready),  32'h0);
        check("rst_res_valid",  32'(res_valid),  32'h0);
        check("rst_res_format", 32'(res_format), 32'h0);
        check("rst_res_abort",  32'(res_abort),  32'h0);
        reset = 1'b1;

        for (int r = 0; r < 13; r++) begin
            cyc();
            req_valid       = tbl[r].valid;
            req_char        = {tbl[r].c1, tbl[r].c0};
            chk_format_type = tbl[r].fmt_in;
            chk_error_code  = tbl[r].err_in;
            #1;
            check($sformatf("row%0d_ready", r), 32'(req_ready),  32'(tbl[r].e_ready));
            check($sformatf("row%0d_chk",   r), 32'(chk_char),   32'(tbl[r].e_chk));
            check($sformatf("row%0d_freq",  r), 32'(chk_freq),   32'(tbl[r].e_freq));
            check($sformatf("row%0d_rv",    r), 32'(res_valid),  32'(tbl[r].e_rv));
            check($sformatf("row%0d_rid",   r), 32'(res_id),     32'(tbl[r].e_rid));
            check($sformatf("row%0d_abort", r), 32'(res_abort),  32'(tbl[r].e_abort));
            check($sformatf("row%0d_fmt",   r), 32'(res_format), 32'(tbl[r].e_fmt));
            check($sformatf("row%0d_err",   r), 32'(res_error),  32'(tbl[r].e_err));
        end

        // Requester 1 drops valid mid-record
        chk_format_type = FMT_MEM;
        chk_error_code  = 4'h7;
        cyc();
        drive(1'b1, 1'b1, CH_START);
        #1;
        check("t3_grant_ready", 32'(req_ready), 32'h2);
        for (int k = 0; k < 4; k++) begin
            cyc();
            drive(1'b1, 1'b1, s3[k]);
        end
        cyc();
        drive(1'b1, 1'b0, 8'h00);
        #1;
        check("t3_last_char", 32'(chk_char), 32'h40);
        cyc();
        check("t3_abort_chk",   32'(chk_char),   32'h0);
        check("t3_abort_flag",  32'(res_abort),  32'h1);
        check("t3_abort_fmt",   32'(res_format), 32'h0);
        check("t3_abort_err",   32'(res_error),  32'h0);
        check("t3_abort_norv",  32'(res_valid),  32'h0);
        cyc();
        check("t3_rv",    32'(res_valid),  32'h1);
        check("t3_rid",   32'(res_id),     32'h1);
        check("t3_abort", 32'(res_abort),  32'h1);
        check("t3_fmt",   32'(res_format), 32'h0);

        // Requester 0 runs into the length limit without a terminator
        cyc();
        drive(1'b0, 1'b1, CH_START);
        for (int n = 2; n <= 64; n++) begin
            cyc();
            drive(1'b0, 1'b1, 8'h78);
            if (n == 64) begin
                #1;
                check("t4_chk_63",   32'(chk_char),  32'h78);
                check("t4_ready_64", 32'(req_ready), 32'h1);
            end
        end
        cyc();
        drive(1'b0, 1'b1, CH_START);
        #1;
        check("t4_abort_chk",   32'(chk_char),  32'h0);
        check("t4_abort_flag",  32'(res_abort), 32'h1);
        check("t4_abort_norv",  32'(res_valid), 32'h0);
        check("t4_resp_ready",  32'(req_ready), 32'h0);
        cyc();
        check("t4_rv",          32'(res_valid), 32'h1);
        check("t4_rid",         32'(res_id),    32'h0);
        check("t4_abort",       32'(res_abort), 32'h1);
        check("t4_regrant",     32'(req_ready), 32'h1);
        cyc();
        check("t4_restart_chk", 32'(chk_char),  32'h5E);
        drive(1'b0, 1'b1, CH_END);
        cyc();
        drive(1'b0, 1'b0, 8'h00);
        cyc();
        cyc();
        check("t4_done_rv",    32'(res_valid),  32'h1);
        check("t4_done_abort", 32'(res_abort),  32'h0);
        check("t4_done_fmt",   32'(res_format), 32'(FMT_MEM));
        check("t4_done_err",   32'(res_error),  32'h7);

        // Reset in the middle of a record (pointer is at 1 beforehand)
        cyc();
        drive(1'b0, 1'b1, CH_START);
        cyc();
        drive(1'b0, 1'b1, 8'h61);
        cyc();
        reset = 1'b0;
        cyc();
        check("t6_chk_char",   32'(chk_char),   32'h0);
        check("t6_chk_freq",   32'(chk_freq),   32'h0);
        check("t6_req_ready",  32'(req_ready),  32'h0);
        check("t6_res_valid",  32'(res_valid),  32'h0);
        check("t6_res_id",     32'(res_id),     32'h0);
        check("t6_res_format", 32'(res_format), 32'h0);
        check("t6_res_error",  32'(res_error),  32'h0);
        check("t6_res_abort",  32'(res_abort),  32'h0);
        reset = 1'b1;
        drive(1'b0, 1'b1, CH_START);
        drive(1'b1, 1'b1, CH_START);
        #1;
        check("t6_idle_ptr0", 32'(req_ready), 32'h1);
        cyc();
        check("t6_start_chk", 32'(chk_char),  32'h5E);
        check("t6_no_rv",     32'(res_valid), 32'h0);
        drive(1'b0, 1'b1, CH_END);
        drive(1'b1, 1'b0, 8'h00);
        cyc();
        drive(1'b0, 1'b0, 8'h00);
        cyc();
        cyc();
        check("t6_after_rv",  32'(res_valid), 32'h1);
        check("t6_after_rid", 32'(res_id),    32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_checker_arbiter.md
# cpu_checker_arbiter

Shares a single `cpu_checker` between `N_REQ` trace-character sources. Records are delimited by `^` and `#`, and the block grants the checker to one source for a whole record. It streams that source's characters into the checker, one per cycle, and latches the checker's verdict, returning it to the owning source. It sits between the trace producers and the `cpu_checker` instance in the checking subsystem.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, 2..4.
- `MAX_LEN`, 64: the longest record in characters, counted from `^` to `#` inclusive, before the block forces an abort.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester character valid
- `req_char`  in  8*N_REQ  per-requester ASCII character; requester i occupies `[8i+7:8i]`
- `req_freq`  in  16*N_REQ  per-requester `freq` value for its records
- `req_ready`  out  N_REQ  a character is accepted on any edge where valid and ready are both high
- `chk_char`  out  8  character driven to the checker
- `chk_freq`  out  16  `freq` driven to the checker
- `chk_format_type`  in  2  from the checker: 0 means none, 1 means register write, 2 means memory write
- `chk_error_code`  in  4  from the checker
- `res_valid`  out  1  one-cycle pulse carrying a record result
- `res_id`  out  $clog2(N_REQ)  index of the owning requester
- `res_format`  out  2  latched `format_type`
- `res_error`  out  4  latched `error_code`
- `res_abort`  out  1  the record was aborted

## Operation
The state machine has four states: IDLE, STREAM, WAIT, RESP.

IDLE:
- `chk_char` is 8'h00.
- A requester is a candidate when its valid is high and its character is `^` (8'h5E).
- The round-robin winner among the candidates gets `req_ready` high in the same cycle.
- When the `^` is accepted:
  - owner ← winner, `chk_freq` ← the owner's `req_freq`, and the length counter ← 1.
  - `chk_char` ← `^`, and the state moves to STREAM.
- A valid requester whose character is not `^` gets `req_ready` high only if it is not the winner and no candidate exists. Its character is consumed and dropped, which discards garbage between records.

STREAM:
- `req_ready` is high for the owner only.
- Each accepted character is registered into `chk_char` unmodified, including any mid-record `^`. The length counter increments on each accepted character.
- An accepted `#` (8'h23) moves the state to WAIT.
- Abort conditions, each giving `chk_char` ← 8'h00, `res_abort` ← 1 and a move to RESP:
  - the owner's valid is low, or
  - the counter reaches `MAX_LEN` without a `#`.
  - On abort, `res_format` and `res_error` are set to 0.

WAIT:
- `chk_char` ← 8'h00, and no requester is ready.
- Next state is RESP, where `res_format` and `res_error` capture `chk_format_type` and `chk_error_code`.

RESP:
- `res_valid` is high for one cycle, with `res_id` equal to the owner.
- The round-robin pointer moves to owner+1 (mod `N_REQ`), and the state returns to IDLE.

`chk_freq` is only changed at grant and holds for the whole record.

## Timing
- On reset, every output goes to 0: `chk_char`=8'h00, `chk_freq`=0, `req_ready`=0, `res_*`=0. The state goes to IDLE and the round-robin pointer to 0.
- Reset mid-record drops the record without producing a result.
- `chk_char` lags the accepted character by one cycle.
- In a `#` result:
  - accepted at edge k,
  - visible on `chk_char` after edge k,
  - taken by the checker at edge k+1, with its outputs valid after k+1,
  - captured by the arbiter at edge k+2, so `res_valid` is high between edges k+2 and k+3.
- Record throughput is one character per cycle.
- The gap between records is 2 cycles (WAIT and RESP) plus the IDLE grant cycle.
- In a simultaneous `^` from several requesters, the lowest index at or after the pointer wins.
- At counter wrap, the counter width is $clog2(MAX_LEN+1), and the counter never wraps because the abort fires at `MAX_LEN`.

## Structure
- Package `checker_arb_pkg` holds:
  - the state enum (IDLE, STREAM, WAIT, RESP),
  - `CH_START`=8'h5E, `CH_END`=8'h23, `CH_NUL`=8'h00,
  - the format codes `FMT_NONE`=0, `FMT_REG`=1, `FMT_MEM`=2.
- Sub-module `rr_arbiter` takes request and pointer and produces a one-hot grant plus an encoded index. It is combinational, and the pointer register stays in the parent.

## Test plan
- Requester 0 streams `^128@000030fd: $31<=..#` with `freq`=16 → `res_valid` 2 cycles after `#` is accepted, `res_id`=0, `res_format`=1, `res_error` equal to the checker's output, `res_abort`=0.
- Both requesters present `^` in the same cycle with the pointer at 0 → requester 0 streams first and requester 1 is held (ready=0) until RESP. Requester 1 is then granted in the next IDLE, and the `res_id` sequence is 0, 1.
- Requester 1 drops valid after `^338@` → `chk_char`=8'h00 the next cycle, then `res_valid` with `res_id`=1, `res_abort`=1, `res_format`=0.
- Requester 0 sends 64 characters with no `#` (`MAX_LEN`=64) → abort on the 64th character, and the requester's next `^` is accepted only in a later IDLE.
- In IDLE, requester 0 sends `a`,`b` and then `^` → `a` and `b` are consumed without reaching `chk_char` (which stays 8'h00), and the record starts at `^`.
- Reset is asserted (`reset`=0) in the middle of a record → the next cycle shows all outputs at 0, no `res_valid`, and the state is IDLE.
